product_accumulator: RTL and testbench

Downstream stage of the 16x16 stream multiplier. Consumes its valid-only 32-bit product stream, which has no backpressure, and sums each group of VEC_LEN consecutive products into one dot-product result. Completed results are buffered in a small FIFO and offered on a ready/valid output stream. Drops and arithmetic wrap are reported through sticky flags.

---
 rtl/product_accumulator_pkg.sv | 14 +
 rtl/product_accumulator_if.sv | 31 +++
 rtl/product_accumulator_fifo.sv | 77 +++++++
 rtl/product_accumulator.sv | 93 +++++++++
 tb/tb_product_accumulator.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared constants and helpers for the product accumulator and its result FIFO.
package product_acc_pkg;

    localparam int unsigned PRODUCT_W      = 32;
    localparam int unsigned VEC_LEN_DEF    = 4;
    localparam int unsigned ACC_W_DEF      = 40;
    localparam int unsigned FIFO_DEPTH_DEF = 2;

    // Occupancy counter width: must be able to represent DEPTH itself.
    function automatic int unsigned level_w(input int unsigned depth);
        return 32'($clog2(depth)) + 32'd1;
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product input stream, result output stream and sticky error flags.
interface product_acc_if
    import product_acc_pkg::*;
#(
    parameter int unsigned ACC_W      = ACC_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) ();

    localparam int unsigned LEVEL_W = level_w(FIFO_DEPTH);

    logic                 i_valid;
    logic [PRODUCT_W-1:0] i_payload;
    logic                 i_flush;
    logic                 o_valid;
    logic                 o_ready;
    logic [ACC_W-1:0]     o_payload;
    logic [LEVEL_W-1:0]   o_level;
    logic                 err_drop;
    logic                 err_wrap;

    modport slave (
        input  i_valid, i_payload, i_flush, o_ready,
        output o_valid, o_payload, o_level, err_drop, err_wrap
    );

    modport master (
        output i_valid, i_payload, i_flush, o_ready,
        input  o_valid, o_payload, o_level, err_drop, err_wrap
    );

endinterface

// File: rtl/product_accumulator_fifo.sv
// Synchronous result FIFO with a registered head word; push and pop may coincide when full.
module acc_result_fifo
    import product_acc_pkg::*;
#(
    parameter  int unsigned WIDTH   = ACC_W_DEF,
    parameter  int unsigned DEPTH   = FIFO_DEPTH_DEF,
    localparam int unsigned LEVEL_W = level_w(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level,
    output logic [WIDTH-1:0]   head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_next_c;
    logic [LEVEL_W-1:0] count_next_c;
    logic               do_push_c;
    logic               do_pop_c;

    always_comb begin
        do_pop_c     = pop && !empty;
        do_push_c    = push && (!full || do_pop_c);
        rd_next_c    = rd_ptr + PTR_W'(1);
        count_next_c = level + LEVEL_W'(do_push_c) - LEVEL_W'(do_pop_c);
    end

    // Storage carries no reset; validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            head   <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_next_c;
            end
            level <= count_next_c;
            full  <= (count_next_c == LEVEL_W'(DEPTH));
            empty <= (count_next_c == '0);
            // Head follows the next entry after a pop, or captures a push into an empty buffer.
            if (do_pop_c) begin
                if (level == LEVEL_W'(1)) begin
                    if (do_push_c) begin
                        head <= push_data;
                    end
                end else begin
                    head <= mem[rd_next_c];
                end
            end else if (do_push_c && empty) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums each group of VEC_LEN products and queues the results on a ready/valid stream.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int unsigned VEC_LEN    = VEC_LEN_DEF,
    parameter int unsigned ACC_W      = ACC_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    product_acc_if.slave  bus
);

    localparam int unsigned CNT_W   = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int unsigned LEVEL_W = level_w(FIFO_DEPTH);

    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   base_c;
    logic [ACC_W:0]     sum_c;
    logic               sample_c;
    logic               last_c;
    logic               push_c;
    logic               pop_c;
    logic               drop_c;
    logic               wrap_c;
    logic               full;
    logic               empty;
    logic [LEVEL_W-1:0] level;
    logic [ACC_W-1:0]   head;
    logic               err_drop_q;
    logic               err_wrap_q;

    // Flush masks the sample, so it also masks any push and error it would cause.
    always_comb begin
        sample_c = bus.i_valid && !bus.i_flush;
        last_c   = (cnt == CNT_W'(VEC_LEN - 1));
        base_c   = (cnt == '0) ? '0 : acc;
        sum_c    = {1'b0, base_c} + (ACC_W + 1)'(bus.i_payload);
        push_c   = sample_c && last_c;
        pop_c    = !empty && bus.o_ready;
        drop_c   = push_c && full && !pop_c;
        wrap_c   = sample_c && sum_c[ACC_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            acc        <= '0;
            err_drop_q <= 1'b0;
            err_wrap_q <= 1'b0;
        end else if (bus.i_flush) begin
            cnt        <= '0;
            acc        <= '0;
            err_drop_q <= 1'b0;
            err_wrap_q <= 1'b0;
        end else begin
            if (sample_c) begin
                if (last_c) begin
                    cnt <= '0;
                    acc <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                    acc <= sum_c[ACC_W-1:0];
                end
            end
            err_drop_q <= err_drop_q | drop_c;
            err_wrap_q <= err_wrap_q | wrap_c;
        end
    end

    acc_result_fifo #(
        .WIDTH (ACC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_data (sum_c[ACC_W-1:0]),
        .pop       (pop_c),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .head      (head)
    );

    assign bus.o_valid   = !empty;
    assign bus.o_payload = head;
    assign bus.o_level   = level;
    assign bus.err_drop  = err_drop_q;
    assign bus.err_wrap  = err_wrap_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: vector table, scripted corner cases and a per-cycle scoreboard model.
module tb_product_accumulator;
    import product_acc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    product_acc_if #(.ACC_W(40), .FIFO_DEPTH(2)) bus ();
    product_acc_if #(.ACC_W(32), .FIFO_DEPTH(2)) wbus ();

    product_accumulator #(.VEC_LEN(4), .ACC_W(40), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    product_accumulator #(.VEC_LEN(2), .ACC_W(32), .FIFO_DEPTH(2)) dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (wbus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Scoreboard: expected FIFO contents in order, plus expected sticky flags.
    logic [39:0] mq [$];
    int          m_cnt;
    logic [39:0] m_acc;
    logic [40:0] m_sum;
    bit          m_drop, m_wrap, m_push, m_pop;

    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
            m_cnt  = 0;
            m_acc  = '0;
            m_drop = 1'b0;
            m_wrap = 1'b0;
        end else begin
            check("sb_valid", 64'(bus.o_valid), 64'(mq.size() != 0));
            check("sb_level", 64'(bus.o_level), 64'(mq.size()));
            if (mq.size() != 0) check("sb_payload", 64'(bus.o_payload), 64'(mq[0]));
            check("sb_drop", 64'(bus.err_drop), 64'(m_drop));
            check("sb_wrap", 64'(bus.err_wrap), 64'(m_wrap));
            m_pop  = (mq.size() != 0) && bus.o_ready;
            m_push = 1'b0;
            if (bus.i_flush) begin
                m_cnt  = 0;
                m_acc  = '0;
                m_drop = 1'b0;
                m_wrap = 1'b0;
            end else if (bus.i_valid) begin
                m_sum = {1'b0, (m_cnt == 0) ? 40'd0 : m_acc} + {9'd0, bus.i_payload};
                if (m_sum[40]) m_wrap = 1'b1;
                if (m_cnt == 3) begin
                    m_cnt  = 0;
                    m_acc  = '0;
                    m_push = 1'b1;
                end else begin
                    m_cnt++;
                    m_acc = m_sum[39:0];
                end
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                if (mq.size() < 2) mq.push_back(m_sum[39:0]);
                else m_drop = 1'b1;
            end
        end
    end

    typedef struct packed {
        logic [3:0][31:0] p;
        logic [39:0]      exp;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input logic [31:0] a, b, c, d, input logic [39:0] e);
        vec_t v;
        v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
        v.exp  = e;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] p);
        bus.i_valid   = v;
        bus.i_payload = p;
        tick();
        bus.i_valid   = 1'b0;
    endtask

    initial begin
        vecs[0] = mk(32'd1, 32'd2, 32'd3, 32'd4, 40'd10);
        vecs[1] = mk(32'd5, 32'd6, 32'd7, 32'd8, 40'd26);
        vecs[2] = mk(32'd0, 32'd0, 32'd0, 32'd0, 40'd0);
        vecs[3] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40'h03_FFFF_FFFC);
        vecs[4] = mk(32'h8000_0000, 32'h8000_0000, 32'd1, 32'd2, 40'h01_0000_0003);
        vecs[5] = mk(32'h1234_5678, 32'h1111_1111, 32'd0, 32'h0101_0101, 40'h00_2446_688A);

        reset = 1'b1;
        bus.i_valid = 1'b0;  bus.i_payload = '0;  bus.i_flush = 1'b0;  bus.o_ready = 1'b0;
        wbus.i_valid = 1'b0; wbus.i_payload = '0; wbus.i_flush = 1'b0; wbus.o_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 64'(bus.o_valid), 64'd0);
        check("rst_payload", 64'(bus.o_payload), 64'd0);
        check("rst_level", 64'(bus.o_level), 64'd0);
        check("rst_drop", 64'(bus.err_drop), 64'd0);
        check("rst_wrap", 64'(bus.err_wrap), 64'd0);
        check("rst_w_payload", 64'(wbus.o_payload), 64'd0);
        reset = 1'b0;
        bus.o_ready = 1'b1;
        tick();

        // Table-driven groups, consumer always ready
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 4; j++) drive(1'b1, vecs[i].p[j]);
            check($sformatf("vec%0d_valid", i), 64'(bus.o_valid), 64'd1);
            check($sformatf("vec%0d_sum", i), 64'(bus.o_payload), 64'(vecs[i].exp));
            tick();
            check($sformatf("vec%0d_level", i), 64'(bus.o_level), 64'd0);
        end

        // Gapped input
        drive(1'b1, 32'd5); drive(1'b0, 32'd0); drive(1'b0, 32'd0);
        drive(1'b1, 32'd6); drive(1'b1, 32'd7); drive(1'b0, 32'd0);
        check("gap_early", 64'(bus.o_valid), 64'd0);
        drive(1'b1, 32'd8);
        check("gap_valid", 64'(bus.o_valid), 64'd1);
        check("gap_sum", 64'(bus.o_payload), 64'd26);
        tick();

        // Backpressure: three groups into a two-entry buffer
        bus.o_ready = 1'b0;
        for (int k = 0; k < 12; k++) drive(1'b1, 32'd1);
        check("bp_level", 64'(bus.o_level), 64'd2);
        check("bp_drop", 64'(bus.err_drop), 64'd1);
        check("bp_head0", 64'(bus.o_payload), 64'd4);
        bus.o_ready = 1'b1;
        tick();
        check("bp_head1", 64'(bus.o_payload), 64'd4);
        check("bp_level1", 64'(bus.o_level), 64'd1);
        tick();
        check("bp_empty", 64'(bus.o_valid), 64'd0);
        check("bp_drop_sticky", 64'(bus.err_drop), 64'd1);
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        check("bp_drop_clr", 64'(bus.err_drop), 64'd0);

        // Full buffer with a pop on the completing cycle
        bus.o_ready = 1'b0;
        for (int k = 0; k < 4; k++) drive(1'b1, 32'd1);
        for (int k = 0; k < 4; k++) drive(1'b1, 32'd2);
        for (int k = 0; k < 3; k++) drive(1'b1, 32'd3);
        check("fp_full", 64'(bus.o_level), 64'd2);
        bus.o_ready = 1'b1;
        drive(1'b1, 32'd3);
        check("fp_level", 64'(bus.o_level), 64'd2);
        check("fp_nodrop", 64'(bus.err_drop), 64'd0);
        check("fp_head", 64'(bus.o_payload), 64'd8);
        tick();
        check("fp_last", 64'(bus.o_payload), 64'd12);
        tick();
        check("fp_empty", 64'(bus.o_level), 64'd0);

        // Wrap on the 32-bit, two-element instance
        wbus.i_valid = 1'b1; wbus.i_payload = 32'hFFFF_FFFF;
        tick();
        wbus.i_payload = 32'd2;
        tick();
        wbus.i_valid = 1'b0;
        check("wrap_valid", 64'(wbus.o_valid), 64'd1);
        check("wrap_sum", 64'(wbus.o_payload), 64'd1);
        check("wrap_flag", 64'(wbus.err_wrap), 64'd1);
        wbus.o_ready = 1'b1;
        tick();
        check("wrap_sticky", 64'(wbus.err_wrap), 64'd1);
        check("wrap_popped", 64'(wbus.o_valid), 64'd0);
        wbus.i_flush = 1'b1;
        tick();
        wbus.i_flush = 1'b0;
        check("wrap_clr", 64'(wbus.err_wrap), 64'd0);

        // Flush beats a coincident sample and drops the partial group
        drive(1'b1, 32'd3); drive(1'b1, 32'd3);
        bus.i_flush = 1'b1;
        drive(1'b1, 32'd9);
        bus.i_flush = 1'b0;
        check("fl_novalid", 64'(bus.o_valid), 64'd0);
        for (int k = 0; k < 4; k++) drive(1'b1, 32'd1);
        check("fl_valid", 64'(bus.o_valid), 64'd1);
        check("fl_sum", 64'(bus.o_payload), 64'd4);
        tick();

        // Asynchronous reset with a queued result and a partial group
        bus.o_ready = 1'b0;
        for (int k = 0; k < 4; k++) drive(1'b1, 32'd2);
        drive(1'b1, 32'd5); drive(1'b1, 32'd5);
        check("mr_level", 64'(bus.o_level), 64'd1);
        reset = 1'b1;
        #1;
        check("mr_valid", 64'(bus.o_valid), 64'd0);
        check("mr_level0", 64'(bus.o_level), 64'd0);
        check("mr_payload", 64'(bus.o_payload), 64'd0);
        tick();
        reset = 1'b0;
        bus.o_ready = 1'b1;
        drive(1'b1, 32'd1); drive(1'b1, 32'd2); drive(1'b1, 32'd3); drive(1'b1, 32'd4);
        check("mr_sum", 64'(bus.o_payload), 64'd10);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
